// File: rtl/cmp_sort_ctrl_if.sv
// Host-side bus of the bubble-sort accelerator: load/read port, start controls and status.
// Optional cycle_cnt signal exists only when SORT_CYCLE_CNT_EN is defined.
interface cmp_sort_ctrl_if #(
  parameter int N  = 8,
  parameter int AW = 3,
  parameter int W  = 32
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          start;
  logic          signed_mode;
  logic          descend;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic [15:0]   swap_cnt;
`ifdef SORT_CYCLE_CNT_EN
  logic [15:0]   cycle_cnt;
`endif

  modport master (
    output wr_en, wr_addr, wr_data, start, signed_mode, descend, rd_addr,
    input  rd_data, busy, done, swap_cnt
`ifdef SORT_CYCLE_CNT_EN
    , input cycle_cnt
`endif
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, signed_mode, descend, rd_addr,
    output rd_data, busy, done, swap_cnt
`ifdef SORT_CYCLE_CNT_EN
    , output cycle_cnt
`endif
  );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// In-place bubble sort over N registers with one shared signed/unsigned comparator and early exit.
// Define SORT_CYCLE_CNT_EN to add the saturating busy-cycle counter output cycle_cnt.
module cmp_sort_ctrl #(
  parameter int N  = 8,
  parameter int AW = 3,
  parameter int W  = 32
) (
  input logic           clk,
  input logic           rst,
  cmp_sort_ctrl_if.slave sort_if
);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_SWAP, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  mem_q [N];
  logic [AW-1:0] j_q, j_d;
  logic [AW-1:0] pass_q, pass_d;
  logic          swapped_q, swapped_d;
  logic [15:0]   swap_cnt_q, swap_cnt_d;
  logic          sgn_q, sgn_d;
  logic          desc_q, desc_d;
  logic          busy_q, done_q;

  logic [AW-1:0] j_nx_s;
  logic [AW-1:0] last_j_s;
  logic [W-1:0]  a_s, b_s;
  logic          lt_s, ne_s, gt_s, ooo_s;
  logic          do_swap_s, adv_s, flag_s;

  assign j_nx_s   = j_q + AW'(1);
  assign last_j_s = AW'(N - 2) - pass_q;
  assign a_s      = mem_q[j_q];
  assign b_s      = mem_q[j_nx_s];

  // Shared comparator: gt is derived from lt/ne so equal entries never look out of order
  assign lt_s  = sgn_q ? ($signed(a_s) < $signed(b_s)) : (a_s < b_s);
  assign ne_s  = (a_s != b_s);
  assign gt_s  = ne_s & ~lt_s;
  assign ooo_s = desc_q ? lt_s : gt_s;

  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    pass_d     = pass_q;
    swapped_d  = swapped_q;
    swap_cnt_d = swap_cnt_q;
    sgn_d      = sgn_q;
    desc_d     = desc_q;
    do_swap_s  = 1'b0;
    adv_s      = 1'b0;
    flag_s     = swapped_q;
    case (state_q)
      S_IDLE: begin
        if (sort_if.start) begin
          sgn_d      = sort_if.signed_mode;
          desc_d     = sort_if.descend;
          swap_cnt_d = 16'd0;
          pass_d     = '0;
          j_d        = '0;
          swapped_d  = 1'b0;
          state_d    = S_CMP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMP: begin
        if (ooo_s) begin
          state_d = S_SWAP;
        end else begin
          adv_s = 1'b1;
        end
      end
      S_SWAP: begin
        do_swap_s = 1'b1;
        swapped_d = 1'b1;
        flag_s    = 1'b1;
        adv_s     = 1'b1;
        if (swap_cnt_q != 16'hFFFF) begin
          swap_cnt_d = swap_cnt_q + 16'd1;
        end else begin
          swap_cnt_d = swap_cnt_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Advance is folded into the CMP/SWAP cycle itself; flag_s already includes this step's swap
    if (adv_s) begin
      if (j_q < last_j_s) begin
        j_d     = j_nx_s;
        state_d = S_CMP;
      end else if (!flag_s || (pass_q == AW'(N - 2))) begin
        state_d = S_DONE;
      end else begin
        pass_d    = pass_q + AW'(1);
        j_d       = '0;
        swapped_d = 1'b0;
        state_d   = S_CMP;
      end
    end else begin
      j_d = j_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      j_q        <= '0;
      pass_q     <= '0;
      swapped_q  <= 1'b0;
      swap_cnt_q <= 16'd0;
      sgn_q      <= 1'b0;
      desc_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      pass_q     <= pass_d;
      swapped_q  <= swapped_d;
      swap_cnt_q <= swap_cnt_d;
      sgn_q      <= sgn_d;
      desc_q     <= desc_d;
      busy_q     <= (state_d == S_CMP) || (state_d == S_SWAP);
      done_q     <= (state_d == S_DONE);
    end
  end

  // Host writes only land while idle; a same-cycle start then sorts the new value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else if ((state_q == S_IDLE) && sort_if.wr_en) begin
      mem_q[sort_if.wr_addr] <= sort_if.wr_data;
    end else if (do_swap_s) begin
      mem_q[j_q]    <= b_s;
      mem_q[j_nx_s] <= a_s;
    end
  end

`ifdef SORT_CYCLE_CNT_EN
  logic [15:0] cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 16'd0;
    end else if ((state_q == S_IDLE) && sort_if.start) begin
      cyc_q <= 16'd0;
    end else if (((state_q == S_CMP) || (state_q == S_SWAP)) && (cyc_q != 16'hFFFF)) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign sort_if.cycle_cnt = cyc_q;
`endif

  assign sort_if.rd_data  = mem_q[sort_if.rd_addr];
  assign sort_if.busy     = busy_q;
  assign sort_if.done     = done_q;
  assign sort_if.swap_cnt = swap_cnt_q;

endmodule
